sprite_fetch_scheduler: RTL
===========================

Name: sprite_fetch_scheduler

Overview:
Time-multiplexes the single SpriteROM read port across all entity slots, one 40-pixel tile column ahead of the beam. At each tile boundary it swaps a prefetched 8-bit sprite row into the display register. It then scans the entity slots for the next tile, issues at most one ROM request, and stages the result. It sits between the VGA counters, the entity bus and SpriteROM, and feeds the pixel-select/colour stage.

Parameters:
NUM_SLOTS, 5, number of 14-bit entity slots; slot 0 has highest priority
TILE_PX, 40, pixels per tile edge
UPSCALE, 5, pixels per sprite texel
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines
V_TOTAL, 525, total lines per frame
BLANK_ROW, 8'hFF, row emitted when no entity is present (all white)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
entities  in  14*NUM_SLOTS  slot i at [14i+13:14i]; per slot [13:10] ID (4'hF = unused), [9:8] orientation, [7:4] tile row, [3:0] tile col
counter_H  in  10  beam horizontal position
counter_V  in  10  beam vertical position
rom_req  out  1  one-cycle read strobe to SpriteROM
rom_sprite_id  out  4  sprite ID, held from rom_req until rom_valid
rom_orientation  out  2  orientation, held with rom_sprite_id
rom_line  out  3  texel line index, held with rom_sprite_id
rom_data  in  8  returned row
rom_valid  in  1  rom_data valid this cycle; any latency of 1 or more cycles
row_bits  out  8  row for the tile column currently under the beam
row_hit  out  1  row_bits came from an entity
row_slot  out  3  winning slot index; 0 when row_hit=0
overrun  out  1  sticky: a fetch missed its tile boundary
clr_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset values: rom_req=0, rom outputs=0, row_bits=BLANK_ROW, row_hit=0, row_slot=0, overrun=0, state=IDLE, staging=BLANK_ROW, discard=0.
- Triggers, evaluated each cycle from counter_H:
  - h = 40k, k=0..14: swap, then scan column k+1 of line counter_V.
  - h = 600: swap; no scan; staging <= BLANK_ROW.
  - h = H_ACTIVE: front <= BLANK_ROW; scan column 0 of line (counter_V+1) wrapped at V_TOTAL.
- Swap: front (row_bits, row_hit, row_slot) <= staging on the trigger clock edge, visible the next cycle (1-cycle latency); the colour stage delays counter_H by one.
- Scan target line tv: if tv >= V_ACTIVE, staging <= BLANK_ROW and state stays IDLE. Otherwise tile_row = tv/40 and rom_line = (tv%40)/UPSCALE.
- FSM:
  - IDLE: wait for a scan trigger.
  - SCAN: one slot per cycle, i = 0..NUM_SLOTS-1. Match when ID != 4'hF, row field = tile_row and col field = target col. The first match is latched and goes to FETCH. No match goes to DONE with staging = BLANK_ROW and hit=0.
  - FETCH: rom_req=1 for one cycle, address held, then WAIT. If discard=1, stay in FETCH without asserting rom_req.
  - WAIT: on rom_valid, staging <= rom_data, hit=1, slot latched, then DONE.
  - DONE: hold staging until the next trigger.
- Budget: NUM_SLOTS + 2 + ROM latency must be 39 cycles or fewer.
- Overrun: a trigger while the state is not IDLE or DONE does the following.
  - Front gets BLANK_ROW, not the partial staging.
  - overrun <= 1.
  - The in-flight scan aborts and the new scan starts.
  - If aborted from WAIT, discard <= 1. The next rom_valid is ignored and clears discard.
- Simultaneous overrun-set and clr_overrun: set wins.
- rom_valid outside WAIT or discard is ignored.
- Entity changes mid-scan: slots already checked are not re-evaluated.
- Reset mid-fetch: returns to IDLE with discard=0; a stale rom_valid is ignored because the state is not WAIT.

Decomposition:
- Shared package holds:
  - Entity field offsets: ID_MSB/LSB, ORI, ROW, COL.
  - ENTITY_UNUSED = 4'hF.
  - TILE_PX, UPSCALE and screen timing constants.
  - State enum: IDLE, SCAN, FETCH, WAIT, DONE.
- One natural sub-module: tile_trigger_decode. It takes counter_H and counter_V and outputs swap, scan_start, target_col, target_line and blank_next, all combinational.

Test Plan:
- Slot 2 = {ID 3, ori 1, row 0, col 1}, all other slots ID F, ROM latency 2 returning 8'hA5. At h=0, v=0, rom_req is seen with id=3, ori=1, line=0. At h=40, row_bits becomes 8'hA5 with row_hit=1 and row_slot=2 one cycle later.
- Slots 0 and 3 both at row 0, col 1 → only slot 0 is fetched; row_slot=0.
- All slots ID F → no rom_req during the line; row_bits=8'hFF and row_hit=0 throughout.
- v=7, entity at row 0, col 0 → at h=640 of line 6, rom_line=(7%40)/5=1; the row appears at h=0 of line 7.
- ROM latency 40 → at the next trigger overrun=1 and row_bits=8'hFF; the late rom_valid is discarded. clr_overrun then returns overrun to 0.
- v=479, h=640 → target line 480 gives no rom_req and staging stays blank. v=524, h=640 wraps to line 0 and the fetch issues.

Source files
------------

// File: rtl/sprite_fetch_scheduler_pkg.sv
// Shared constants for the sprite fetch scheduler: entity field layout,
// screen timing, FSM state codes and the line-to-tile arithmetic helpers.
package sprite_fetch_scheduler_pkg;

    localparam int ID_MSB  = 13;
    localparam int ID_LSB  = 10;
    localparam int ORI_MSB = 9;
    localparam int ORI_LSB = 8;
    localparam int ROW_MSB = 7;
    localparam int ROW_LSB = 4;
    localparam int COL_MSB = 3;
    localparam int COL_LSB = 0;

    localparam logic [3:0] ENTITY_UNUSED = 4'hF;
    localparam logic [7:0] BLANK_ROW     = 8'hFF;

    localparam int TILE_PX  = 40;
    localparam int UPSCALE  = 5;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int NUM_COLS = H_ACTIVE / TILE_PX;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Compare ladders instead of dividers: only visible lines (< 480) reach these.
    function automatic logic [3:0] line_tile_row(input logic [9:0] tv);
        logic [3:0] row;
        row = '0;
        for (int r = 1; r < V_ACTIVE / TILE_PX; r++)
            if (tv >= 10'(r * TILE_PX)) row = 4'(r);
        return row;
    endfunction

    function automatic logic [2:0] line_texel(input logic [9:0] tv);
        logic [9:0] rem;
        logic [2:0] texel;
        rem   = tv - 10'(TILE_PX) * 10'(line_tile_row(tv));
        texel = '0;
        for (int t = 1; t < TILE_PX / UPSCALE; t++)
            if (rem >= 10'(t * UPSCALE)) texel = 3'(t);
        return texel;
    endfunction

endpackage

// File: rtl/sprite_fetch_scheduler_if.sv
// SpriteROM read port: one-cycle request strobe with held address, data
// returned with rom_valid after an arbitrary latency.
interface sprite_fetch_scheduler_if;
    logic       rom_req;
    logic [3:0] rom_sprite_id;
    logic [1:0] rom_orientation;
    logic [2:0] rom_line;
    logic [7:0] rom_data;
    logic       rom_valid;

    modport master (
        output rom_req, rom_sprite_id, rom_orientation, rom_line,
        input  rom_data, rom_valid
    );

    modport slave (
        input  rom_req, rom_sprite_id, rom_orientation, rom_line,
        output rom_data, rom_valid
    );
endinterface

// File: rtl/sprite_fetch_scheduler_tile_trigger_decode.sv
// Decodes the beam position into tile-boundary events and the column/line
// that the following scan should prepare.
module tile_trigger_decode
    import sprite_fetch_scheduler_pkg::*;
(
    input  logic [9:0] counter_H,
    input  logic [9:0] counter_V,
    output logic       swap,
    output logic       scan_start,
    output logic       blank_next,
    output logic [3:0] target_col,
    output logic [9:0] target_line
);
    logic [NUM_COLS-1:0] at_edge;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_edge
            assign at_edge[gi] = (counter_H == 10'(gi * TILE_PX));
        end
    endgenerate

    // The last boundary (h=600) swaps but has no column left to prefetch;
    // h=H_ACTIVE prefetches column 0 of the next line.
    assign blank_next = (counter_H == 10'(H_ACTIVE));
    assign swap       = |at_edge;
    assign scan_start = (|at_edge[NUM_COLS-2:0]) | blank_next;

    always_comb begin
        target_col = '0;
        for (int k = 0; k < NUM_COLS - 1; k++)
            if (at_edge[k]) target_col = 4'(k + 1);
    end

    assign target_line = !blank_next                        ? counter_V :
                         (counter_V >= 10'(V_TOTAL - 1))    ? 10'd0     :
                                                              counter_V + 10'd1;
endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Prefetches one sprite row per tile column: scans entity slots in priority
// order, issues a single SpriteROM read and swaps the result in at the boundary.
module sprite_fetch_scheduler
    import sprite_fetch_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [14*NUM_SLOTS-1:0] entities,
    input  logic [9:0]              counter_H,
    input  logic [9:0]              counter_V,
    sprite_fetch_scheduler_if.master rom,
    output logic [7:0]              row_bits,
    output logic                    row_hit,
    output logic [2:0]              row_slot,
    output logic                    overrun,
    input  logic                    clr_overrun
);
    logic       swap, scan_start, blank_next;
    logic [3:0] target_col;
    logic [9:0] target_line;

    tile_trigger_decode u_decode (
        .counter_H  (counter_H),
        .counter_V  (counter_V),
        .swap       (swap),
        .scan_start (scan_start),
        .blank_next (blank_next),
        .target_col (target_col),
        .target_line(target_line)
    );

    logic [2:0] state_reg, slot_idx_reg, match_slot_reg, scan_line_reg;
    logic [3:0] tile_row_reg, col_reg, rom_id_reg;
    logic [1:0] rom_ori_reg;
    logic [2:0] rom_line_reg;
    logic [7:0] staging_bits_reg, front_bits_reg;
    logic       staging_hit_reg, front_hit_reg;
    logic [2:0] staging_slot_reg, front_slot_reg;
    logic       discard_reg, overrun_reg;

    // Pad the slot array to the index width so the scan mux never selects out of range.
    logic [13:0] slot_word [8];
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            if (gi < NUM_SLOTS) begin : g_used
                assign slot_word[gi] = entities[14*gi +: 14];
            end else begin : g_pad
                assign slot_word[gi] = {ENTITY_UNUSED, 10'd0};
            end
        end
    endgenerate

    logic [13:0] cur_slot;
    logic        slot_match, trigger, busy, abort, scan_go;

    assign cur_slot   = slot_word[slot_idx_reg];
    assign slot_match = (cur_slot[ID_MSB:ID_LSB] != ENTITY_UNUSED) &&
                        (cur_slot[ROW_MSB:ROW_LSB] == tile_row_reg) &&
                        (cur_slot[COL_MSB:COL_LSB] == col_reg);
    assign trigger    = swap | scan_start;
    assign busy       = (state_reg == S_SCAN) || (state_reg == S_FETCH) || (state_reg == S_WAIT);
    assign abort      = trigger && busy;
    assign scan_go    = scan_start && (target_line < 10'(V_ACTIVE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            slot_idx_reg     <= '0;
            match_slot_reg   <= '0;
            scan_line_reg    <= '0;
            tile_row_reg     <= '0;
            col_reg          <= '0;
            rom_id_reg       <= '0;
            rom_ori_reg      <= '0;
            rom_line_reg     <= '0;
            staging_bits_reg <= BLANK_ROW;
            staging_hit_reg  <= 1'b0;
            staging_slot_reg <= '0;
            front_bits_reg   <= BLANK_ROW;
            front_hit_reg    <= 1'b0;
            front_slot_reg   <= '0;
            discard_reg      <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            if (abort)            overrun_reg <= 1'b1;
            else if (clr_overrun) overrun_reg <= 1'b0;

            // A late fetch shows blank rather than whatever partial staging exists.
            if (swap && !abort) begin
                front_bits_reg <= staging_bits_reg;
                front_hit_reg  <= staging_hit_reg;
                front_slot_reg <= staging_slot_reg;
            end else if (blank_next || abort) begin
                front_bits_reg <= BLANK_ROW;
                front_hit_reg  <= 1'b0;
                front_slot_reg <= '0;
            end

            // A response landing on the abort edge itself is already consumed.
            if (abort && state_reg == S_WAIT && !rom.rom_valid) discard_reg <= 1'b1;
            else if (rom.rom_valid)                             discard_reg <= 1'b0;

            if (trigger) begin
                staging_bits_reg <= BLANK_ROW;
                staging_hit_reg  <= 1'b0;
                staging_slot_reg <= '0;
                if (scan_go) begin
                    state_reg     <= S_SCAN;
                    slot_idx_reg  <= '0;
                    tile_row_reg  <= line_tile_row(target_line);
                    col_reg       <= target_col;
                    scan_line_reg <= line_texel(target_line);
                end else begin
                    state_reg <= S_IDLE;
                end
            end else begin
                case (state_reg)
                    S_SCAN: begin
                        if (slot_match) begin
                            state_reg      <= S_FETCH;
                            match_slot_reg <= slot_idx_reg;
                            rom_id_reg     <= cur_slot[ID_MSB:ID_LSB];
                            rom_ori_reg    <= cur_slot[ORI_MSB:ORI_LSB];
                            rom_line_reg   <= scan_line_reg;
                        end else if (slot_idx_reg == 3'(NUM_SLOTS - 1)) begin
                            state_reg <= S_DONE;
                        end else begin
                            slot_idx_reg <= slot_idx_reg + 3'd1;
                        end
                    end
                    S_FETCH: if (!discard_reg) state_reg <= S_WAIT;
                    S_WAIT: begin
                        if (rom.rom_valid) begin
                            staging_bits_reg <= rom.rom_data;
                            staging_hit_reg  <= 1'b1;
                            staging_slot_reg <= match_slot_reg;
                            state_reg        <= S_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rom.rom_req         = (state_reg == S_FETCH) && !discard_reg;
    assign rom.rom_sprite_id   = rom_id_reg;
    assign rom.rom_orientation = rom_ori_reg;
    assign rom.rom_line        = rom_line_reg;

    assign row_bits = front_bits_reg;
    assign row_hit  = front_hit_reg;
    assign row_slot = front_slot_reg;
    assign overrun  = overrun_reg;
endmodule
